imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/instr_ram.sv | 30 +++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: definitions shared by the instruction-memory loader.
//   state_t        - loader FSM states (IDLE, LEN, DATA, DONE)
//   BYTES_PER_WORD - bytes assembled into each 32-bit instruction word
//   BCNT_W         - width of the per-word byte counter
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_ram.sv
// instr_ram: 32-bit wide, 2**ADDR_WIDTH deep instruction store.
// One synchronous write port and one asynchronous read port; no reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write word address
//   wdata - write data
//   raddr - read word address
//   rdata - combinational read data
module instr_ram #(
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a program into instruction memory from a byte stream
// and serves CPU instruction fetches from the same memory.
// Stream format: 16-bit word count N (little-endian), then N words of
// 4 bytes each (little-endian). The CPU is held in reset until a load ends.
//   clk        - clock
//   reset      - asynchronous active-high reset
//   load_start - one-cycle pulse requesting a (re)load
//   rx_data    - incoming load byte
//   rx_valid   - rx_data is valid
//   rx_ready   - loader accepts a byte this cycle
//   addr       - CPU instruction byte address
//   data       - instruction word at addr (combinational)
//   cpu_hold   - holds the CPU in reset while high
//   load_done  - last load completed
//   overflow   - last load declared more words than the memory depth
// ADDR_WIDTH is limited to 1..16 (word count is 16 bits).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] addr,
  output logic [31:0] data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        overflow
);

  localparam logic [16:0]       DEPTH     = 17'(2 ** ADDR_WIDTH);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

  state_t            state;
  logic [BCNT_W-1:0] byte_cnt;
  logic [7:0]        len_lo;
  logic [7:0]        b0, b1, b2;
  logic [15:0]       n_words;
  logic [15:0]       word_idx;

  logic              accept;
  logic [15:0]       len_word;
  logic              in_range;
  logic              last_word;
  logic              word_done;
  logic              we;
  logic              unused_addr_bits;

  assign rx_ready  = (state == LEN) || (state == DATA);
  assign cpu_hold  = (state != DONE);
  assign load_done = (state == DONE);

  assign accept    = rx_valid && rx_ready;
  assign len_word  = {rx_data, len_lo};
  assign in_range  = ({1'b0, word_idx} < DEPTH);
  assign last_word = (word_idx == n_words - 16'd1);
  assign word_done = (state == DATA) && accept && (byte_cnt == LAST_BYTE);

  // Words beyond the depth are still counted so the stream stays in sync,
  // they are simply never written.
  assign we = word_done && in_range;

  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      word_idx <= '0;
      n_words  <= '0;
      len_lo   <= '0;
      b0       <= '0;
      b1       <= '0;
      b2       <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load_start) begin
            state    <= LEN;
            byte_cnt <= '0;
            word_idx <= '0;
            overflow <= 1'b0;
          end
        end
        LEN: begin
          if (accept) begin
            if (byte_cnt == '0) begin
              len_lo   <= rx_data;
              byte_cnt <= BCNT_W'(1);
            end else begin
              n_words  <= len_word;
              byte_cnt <= '0;
              state    <= (len_word == 16'd0) ? DONE : DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + BCNT_W'(1);
            case (byte_cnt)
              BCNT_W'(0): b0 <= rx_data;
              BCNT_W'(1): b1 <= rx_data;
              BCNT_W'(2): b2 <= rx_data;
              default: begin
                word_idx <= word_idx + 16'd1;
                if (last_word) begin
                  state    <= DONE;
                  overflow <= ({1'b0, n_words} > DEPTH);
                end
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  instr_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(word_idx[ADDR_WIDTH-1:0]),
    .wdata({rx_data, b2, b1, b0}),
    .raddr(addr[ADDR_WIDTH+1:2]),
    .rdata(data)
  );

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader (ADDR_WIDTH = 2, depth 4).
// A stream-level model tracks every accepted byte and derives the expected
// memory image and status outputs; a negedge process compares every cycle.
module tb_imem_loader;

  localparam int unsigned AW    = 2;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] addr;
  logic [31:0] data;
  logic        cpu_hold;
  logic        load_done;
  logic        overflow;

  imem_loader #(
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .addr      (addr),
    .data      (data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;
  bit run = 0;
  int unsigned sweep = 0;

  // Stream-level model
  logic [31:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];
  bit          m_loading;
  bit          m_done;
  logic [7:0]  m_q [$];
  logic [31:0] words_buf [8];

  function automatic int m_n();
    if (m_q.size() < 2) return 0;
    return int'({m_q[1], m_q[0]});
  endfunction

  function automatic void m_reset();
    m_loading = 0;
    m_done    = 0;
  endfunction

  function automatic void m_start();
    m_loading = 1;
    m_done    = 0;
    m_q.delete();
  endfunction

  function automatic void m_accept(input logic [7:0] b);
    int s;
    int w;
    m_q.push_back(b);
    s = m_q.size();
    if (s > 2 && ((s - 2) % 4) == 0) begin
      w = (s - 2) / 4 - 1;
      if (w < DEPTH) begin
        m_mem[w] = {m_q[s-1], m_q[s-2], m_q[s-3], m_q[s-4]};
        m_vld[w] = 1;
      end
    end
    if (s >= 2 && s == 2 + 4 * m_n()) begin
      m_loading = 0;
      m_done    = 1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_loading});
      chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !m_done});
      chk("load_done", {31'd0, load_done}, {31'd0, m_done});
      chk("overflow", {31'd0, overflow}, {31'd0, m_done && (m_n() > DEPTH)});
      if (m_vld[addr[3:2]]) chk("data", data, m_mem[addr[3:2]]);
    end
  end

  // One clock cycle of stimulus, entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [7:0] d, input logic ls);
    bit acc;
    bit st;
    rx_valid   = v;
    rx_data    = d;
    load_start = ls;
    addr       = sweep * 32'd5;
    sweep++;
    acc = v && m_loading;
    st  = ls && !m_loading;
    @(posedge clk);
    #1;
    if (st) m_start();
    else if (acc) m_accept(d);
    rx_valid   = 0;
    load_start = 0;
  endtask

  task automatic check_word(input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk("word", data, exp);
  endtask

  task automatic send_load(input int n, input int gap);
    logic [15:0] nl;
    logic [31:0] w;
    nl = 16'(n);
    cyc(0, 8'h00, 1);
    cyc(1, nl[7:0], 0);
    repeat (gap) cyc(0, 8'hEE, 0);
    cyc(1, nl[15:8], 0);
    repeat (gap) cyc(0, 8'hEE, 0);
    for (int i = 0; i < n; i++) begin
      w = words_buf[i];
      for (int b = 0; b < 4; b++) begin
        cyc(1, w[8*b +: 8], 0);
        repeat (gap) cyc(0, 8'hEE, 0);
      end
    end
  endtask

  initial begin
    logic [7:0]  t1 [6];
    logic [31:0] w;
    t1 = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
    reset = 1; load_start = 0; rx_valid = 0; rx_data = 0; addr = 0;
    m_reset();
    run = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("reset cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("reset load_done", {31'd0, load_done}, 32'd0);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    reset = 0;
    cyc(1, 8'h77, 0);  // byte offered in IDLE is ignored

    // Single-word load, back-to-back bytes
    cyc(0, 8'h00, 1);
    for (int i = 0; i < 6; i++) cyc(1, t1[i], 0);
    chk("single load_done", {31'd0, load_done}, 32'd1);
    chk("single cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check_word(32'h0000_0000, 32'h0010_0513);
    check_word(32'h0000_0013, 32'h0010_0513);
    check_word(32'hFFFF_FFF0, 32'h0010_0513);

    // Zero length keeps previous contents
    send_load(0, 0);
    chk("zero load_done", {31'd0, load_done}, 32'd1);
    check_word(32'h0, 32'h0010_0513);

    // Backpressure: rx_valid every other cycle
    cyc(1, 8'h66, 0);  // byte offered in DONE is ignored
    words_buf[0] = 32'h1122_3344;
    words_buf[1] = 32'h5566_7788;
    words_buf[2] = 32'h99AA_BBCC;
    send_load(3, 1);
    check_word(32'h0, 32'h1122_3344);
    check_word(32'h4, 32'h5566_7788);
    check_word(32'h8, 32'h99AA_BBCC);

    // Exactly depth: no overflow
    for (int i = 0; i < 4; i++) words_buf[i] = 32'hB000_0000 + 32'(i);
    send_load(4, 0);
    chk("full overflow", {31'd0, overflow}, 32'd0);
    check_word(32'hC, 32'hB000_0003);

    // Overflow: 6 words into depth 4
    for (int i = 0; i < 6; i++) words_buf[i] = 32'hA000_0000 + 32'(i);
    send_load(6, 0);
    chk("ovf overflow", {31'd0, overflow}, 32'd1);
    chk("ovf load_done", {31'd0, load_done}, 32'd1);
    check_word(32'h0, 32'hA000_0000);
    check_word(32'h4, 32'hA000_0001);
    check_word(32'h8, 32'hA000_0002);
    check_word(32'hC, 32'hA000_0003);

    // Reset after 5 of 8 data bytes
    w = 32'hDEAD_BEEF;
    cyc(0, 8'h00, 1);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h00, 0);
    for (int b = 0; b < 4; b++) cyc(1, w[8*b +: 8], 0);
    cyc(1, 8'h0D, 0);
    reset = 1;
    m_reset();
    #1;
    chk("midrst cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("midrst rx_ready", {31'd0, rx_ready}, 32'd0);
    check_word(32'h0, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    reset = 0;
    cyc(1, 8'h55, 0);
    words_buf[0] = 32'hCAFE_F00D;
    send_load(1, 0);
    check_word(32'h0, 32'hCAFE_F00D);

    // load_start during DATA is ignored; reload from DONE
    w = 32'h1234_5678;
    cyc(0, 8'h00, 1);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h00, 0);
    for (int b = 0; b < 4; b++) cyc(1, w[8*b +: 8], (b == 2));
    w = 32'h9ABC_DEF0;
    for (int b = 0; b < 4; b++) cyc(1, w[8*b +: 8], 0);
    chk("ign load_done", {31'd0, load_done}, 32'd1);
    check_word(32'h0, 32'h1234_5678);
    check_word(32'h4, 32'h9ABC_DEF0);
    cyc(0, 8'h00, 1);
    chk("reload cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("reload load_done", {31'd0, load_done}, 32'd0);
    chk("reload rx_ready", {31'd0, rx_ready}, 32'd1);
    cyc(1, 8'h00, 0);
    cyc(1, 8'h00, 0);
    chk("reload0 load_done", {31'd0, load_done}, 32'd1);
    check_word(32'h0, 32'h1234_5678);

    cyc(0, 8'h00, 0);
    run = 0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
